mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Shares the single memory port (mem_control_t ctrl / rdata) between the hart's instruction-fetch
//   (IF) and load/store (LS) requesters. Grants one request at a time, holds the request stable on
//   the memory port for the read latency, returns the read data with a one-cycle response pulse, and
//   gates wenable to exactly one cycle per store. Sits between the hart core and memory.
// PARAMETERS
//   READ_LATENCY  1  cycles from address presented to mem_rdata valid (ROM/RAM = 1; 0 for periph-only)
// PORTS
//   clock          in   1              system clock, all state on posedge
//   reset          in   1              asynchronous, active-high
//   if_req_valid   in   1              IF read request
//   if_req_ready   out  1              IF request accepted this cycle
//   if_req_addr    in   XLEN           IF word address
//   if_resp_valid  out  1              one-cycle pulse: if_resp_data valid
//   if_resp_data   out  XLEN           fetched word
//   ls_req_valid   in   1              LS request
//   ls_req_ready   out  1              LS request accepted this cycle
//   ls_req_addr    in   XLEN           LS byte address
//   ls_req_wenable in   1              1 = store, 0 = load
//   ls_req_wwidth  in   write_width_t  store width (byte/halfword/word)
//   ls_req_wdata   in   XLEN           store data
//   ls_resp_valid  out  1              one-cycle pulse: load data valid / store done
//   ls_resp_data   out  XLEN           load data; 0 for stores
//   mem_ctrl       out  mem_control_t  to memory ctrl (addr, wenable, wwidth, wdata)
//   mem_rdata      in   XLEN           from memory rdata
// BEHAVIOUR
//   - Reset: state IDLE, all ready/resp_valid 0, resp_data 0, mem_ctrl all-zero, RR pointer -> LS.
//   - States: IDLE -> WAIT -> RESP -> IDLE. Cycle T = handshake (valid & ready, IDLE only).
//   - IDLE: ready = 1 only for the winner, combinational from valid; loser's ready = 0.
//     Handshake latches owner, addr, wenable, wwidth, wdata; go to WAIT, counter = READ_LATENCY.
//     READ_LATENCY = 0: skip WAIT, go straight to RESP.
//   - WAIT (T+1 .. T+READ_LATENCY): mem_ctrl from latched regs; mem_ctrl.wenable = 1 only in T+1;
//     counter decrements; at 1 go to RESP.
//   - RESP (T+1+READ_LATENCY): addr still held, wenable 0; owner's resp_valid = 1, resp_data = mem_rdata
//     (load/fetch) or 0 (store); other requester's resp_valid = 0. Next cycle IDLE.
//   - Throughput: one transaction per READ_LATENCY+2 cycles; no ready in WAIT/RESP.
//   - Requesters hold valid and payload stable until ready; arbiter need not tolerate withdrawal.
//   - Outside WAIT: mem_ctrl.wenable = 0, addr keeps last latched value.
//   - Addresses and wwidth pass through unmodified; alignment is the requester's job.
//   - IF requests are always reads; store data/width are ignored for IF.
//   - Simultaneous valid: arbitration per CONFIGURATION; single valid always wins.
//   - Reset mid-transaction: wenable drops asynchronously; in-flight txn dropped, no resp pulse;
//     requesters reissue.
// CONFIGURATION
//   MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority, LS beats IF on every tie.
//   MEM_ARB_ROUND_ROBIN_EN defined: 1-bit pointer; tie goes to the requester not granted last; pointer
//     updates on every handshake; single-requester grants also update it.
// TESTING
//   1. IF read 0x0004, LAT=1: if_req_ready=1 @T; mem_ctrl.addr=0x0004 @T+1..T+2;
//      if_resp_valid=1 only @T+2, data = ROM word 1.
//   2. LS store word 0x0800=0xDEADBEEF then load 0x0800: wenable high only @T+1;
//      ls_resp_data=0 on store, 0xDEADBEEF on load.
//   3. IF+LS valid same cycle, macro off: LS granted first; IF ready in first IDLE after LS RESP;
//      repeat x3, LS always first.
//   4. Same with MEM_ARB_ROUND_ROBIN_EN: grants alternate LS, IF, LS, IF...
//   5. LS byte store 0x1800=0x5A (write_byte): periph[0]=0x5A, periph[1..3] unchanged;
//      ls_resp_valid @T+2.
//   6. Reset asserted mid-WAIT of store: wenable 0 same cycle, no resp_valid after release;
//      READ_LATENCY=0 build: resp @T+1.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IF/LS memory port arbiter; MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-break
package mem_arbiter_pkg;
  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    WRITE_BYTE = 2'd0,
    WRITE_HALF = 2'd1,
    WRITE_WORD = 2'd2
  } write_width_t;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic            wenable;
    write_width_t    wwidth;
    logic [XLEN-1:0] wdata;
  } mem_control_t;
endpackage

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            if_req_valid,
  output logic            if_req_ready,
  input  logic [XLEN-1:0] if_req_addr,
  output logic            if_resp_valid,
  output logic [XLEN-1:0] if_resp_data,
  input  logic            ls_req_valid,
  output logic            ls_req_ready,
  input  logic [XLEN-1:0] ls_req_addr,
  input  logic            ls_req_wenable,
  input  write_width_t    ls_req_wwidth,
  input  logic [XLEN-1:0] ls_req_wdata,
  output logic            ls_resp_valid,
  output logic [XLEN-1:0] ls_resp_data,
  output mem_control_t    mem_ctrl,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int CW = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);
  localparam logic [CW-1:0] LAT_C = CW'(READ_LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            owner_ls_q, owner_ls_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            we_q, we_d;
  write_width_t    wwidth_q, wwidth_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            ls_win, if_win, first_cycle;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // rr_if_q = 1 means IF wins the next tie (LS was granted last)
  logic rr_if_q, rr_if_d;
  assign ls_win = ls_req_valid && !(if_req_valid && rr_if_q);
`else
  assign ls_win = ls_req_valid;
`endif
  assign if_win = if_req_valid && !ls_win;

  // Store strobe lives in the first cycle after the handshake; with zero
  // latency that cycle is RESP itself, otherwise the first WAIT cycle.
  assign first_cycle = (READ_LATENCY == 0) ? (state_q == RESP)
                                           : ((state_q == WAIT) && (cnt_q == LAT_C));

  // State and latched-request registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      owner_ls_q <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wwidth_q   <= WRITE_BYTE;
      wdata_q    <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_if_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_ls_q <= owner_ls_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wwidth_q   <= wwidth_d;
      wdata_q    <= wdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_if_q    <= rr_if_d;
`endif
    end
  end

  // Next-state: grant in IDLE, count down the read latency, one RESP cycle
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_ls_d = owner_ls_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wwidth_d   = wwidth_q;
    wdata_d    = wdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    rr_if_d    = rr_if_q;
`endif
    case (state_q)
      IDLE: begin
        if (ls_win || if_win) begin
          owner_ls_d = ls_win;
          addr_d     = ls_win ? ls_req_addr : if_req_addr;
          // IF is read-only, so its store fields are forced quiet
          we_d       = ls_win && ls_req_wenable;
          wwidth_d   = ls_win ? ls_req_wwidth : WRITE_BYTE;
          wdata_d    = ls_win ? ls_req_wdata : '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          rr_if_d    = ls_win;
`endif
          if (READ_LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_C;
          end
        end
      end
      WAIT: begin
        if (cnt_q == CW'(1)) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: ready only in IDLE, response pulse in RESP, memory port from latches
  always_comb begin
    ls_req_ready     = (state_q == IDLE) && !reset && ls_win;
    if_req_ready     = (state_q == IDLE) && !reset && if_win;
    ls_resp_valid    = (state_q == RESP) && owner_ls_q;
    if_resp_valid    = (state_q == RESP) && !owner_ls_q;
    ls_resp_data     = (ls_resp_valid && !we_q) ? mem_rdata : '0;
    if_resp_data     = if_resp_valid ? mem_rdata : '0;
    mem_ctrl.addr    = addr_q;
    mem_ctrl.wenable = we_q && first_cycle;
    mem_ctrl.wwidth  = wwidth_q;
    mem_ctrl.wdata   = wdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int LAT = 1;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         if_req_valid, if_req_ready, if_resp_valid;
  logic [31:0]  if_req_addr, if_resp_data;
  logic         ls_req_valid, ls_req_ready, ls_req_wenable, ls_resp_valid;
  logic [31:0]  ls_req_addr, ls_req_wdata, ls_resp_data;
  write_width_t ls_req_wwidth;
  mem_control_t mem_ctrl;
  logic [31:0]  mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.READ_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
    .ls_req_wenable(ls_req_wenable), .ls_req_wwidth(ls_req_wwidth), .ls_req_wdata(ls_req_wdata),
    .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data),
    .mem_ctrl(mem_ctrl), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Memory device behind the port: byte array, one-cycle registered read
  logic [7:0] dev_mem [0:8191];
  bit dev_init = 1'b0;
  always @(posedge clock) begin
    if (!dev_init) begin
      for (int i = 0; i < 8192; i++) dev_mem[i] <= 8'(i * 7 + 3);
      dev_init <= 1'b1;
    end else begin
      if (mem_ctrl.wenable) begin
        case (mem_ctrl.wwidth)
          WRITE_BYTE: dev_mem[mem_ctrl.addr[12:0]] <= mem_ctrl.wdata[7:0];
          WRITE_HALF: begin
            dev_mem[mem_ctrl.addr[12:0]]        <= mem_ctrl.wdata[7:0];
            dev_mem[mem_ctrl.addr[12:0] + 13'd1] <= mem_ctrl.wdata[15:8];
          end
          default: begin
            dev_mem[{mem_ctrl.addr[12:2], 2'd0}] <= mem_ctrl.wdata[7:0];
            dev_mem[{mem_ctrl.addr[12:2], 2'd1}] <= mem_ctrl.wdata[15:8];
            dev_mem[{mem_ctrl.addr[12:2], 2'd2}] <= mem_ctrl.wdata[23:16];
            dev_mem[{mem_ctrl.addr[12:2], 2'd3}] <= mem_ctrl.wdata[31:24];
          end
        endcase
      end
      mem_rdata <= {dev_mem[{mem_ctrl.addr[12:2], 2'd3}], dev_mem[{mem_ctrl.addr[12:2], 2'd2}],
                    dev_mem[{mem_ctrl.addr[12:2], 2'd1}], dev_mem[{mem_ctrl.addr[12:2], 2'd0}]};
    end
  end

  // Reference model: phase = cycles since grant (-1 idle); transaction ends at phase LAT+1
  logic [7:0]   ref_mem [0:8191];
  int           phase;
  bit           m_owner_ls, m_we, last_ls;
  logic [31:0]  m_addr, m_wdata;
  write_width_t m_wwidth;
  bit           grants[$];

  initial begin
    bit prio_ls, e_ls_w, e_if_w, resp;
    logic [31:0] e_word;
    logic [12:0] wa;
    for (int i = 0; i < 8192; i++) ref_mem[i] = 8'(i * 7 + 3);
    phase = -1; last_ls = 1'b0; m_addr = '0; m_we = 1'b0; m_owner_ls = 1'b0;
    m_wdata = '0; m_wwidth = WRITE_BYTE;
    forever begin
      @(negedge clock);
      if (reset) begin
        phase = -1; last_ls = 1'b0; m_addr = '0; m_we = 1'b0;
        continue;
      end
`ifdef MEM_ARB_ROUND_ROBIN_EN
      prio_ls = !last_ls;
`else
      prio_ls = 1'b1;
`endif
      e_ls_w = (phase < 0) && ls_req_valid && (!if_req_valid || prio_ls);
      e_if_w = (phase < 0) && if_req_valid && !e_ls_w;
      resp   = (phase == LAT + 1);
      wa     = {m_addr[12:2], 2'b00};
      e_word = {ref_mem[wa + 13'd3], ref_mem[wa + 13'd2], ref_mem[wa + 13'd1], ref_mem[wa]};
      chk("ls_req_ready", 32'(ls_req_ready), 32'(e_ls_w));
      chk("if_req_ready", 32'(if_req_ready), 32'(e_if_w));
      chk("ls_resp_valid", 32'(ls_resp_valid), 32'(resp && m_owner_ls));
      chk("if_resp_valid", 32'(if_resp_valid), 32'(resp && !m_owner_ls));
      chk("ls_resp_data", ls_resp_data, (resp && m_owner_ls && !m_we) ? e_word : 32'h0);
      chk("if_resp_data", if_resp_data, (resp && !m_owner_ls) ? e_word : 32'h0);
      chk("mem_addr", mem_ctrl.addr, m_addr);
      chk("mem_wenable", 32'(mem_ctrl.wenable), 32'(phase == 1 && m_we));
      if (e_ls_w || e_if_w) begin
        phase      = 1;
        m_owner_ls = e_ls_w;
        last_ls    = e_ls_w;
        m_addr     = e_ls_w ? ls_req_addr : if_req_addr;
        m_we       = e_ls_w && ls_req_wenable;
        m_wwidth   = ls_req_wwidth;
        m_wdata    = ls_req_wdata;
        grants.push_back(e_ls_w);
      end else if (phase >= 1) begin
        if (phase == 1 && m_we) begin
          case (m_wwidth)
            WRITE_BYTE: ref_mem[m_addr[12:0]] = m_wdata[7:0];
            WRITE_HALF: begin
              ref_mem[m_addr[12:0]]         = m_wdata[7:0];
              ref_mem[m_addr[12:0] + 13'd1] = m_wdata[15:8];
            end
            default: for (int b = 0; b < 4; b++) ref_mem[wa + 13'(b)] = m_wdata[8*b +: 8];
          endcase
        end
        phase = (phase == LAT + 1) ? -1 : phase + 1;
      end
    end
  end

  task automatic ls_txn(input logic [31:0] a, input bit we, input write_width_t w,
                        input logic [31:0] d, output logic [31:0] rd);
    bit got;
    @(posedge clock); #1;
    ls_req_addr = a; ls_req_wenable = we; ls_req_wwidth = w; ls_req_wdata = d; ls_req_valid = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (ls_req_ready) begin got = 1'b1; break; end
    end
    @(posedge clock); #1;
    ls_req_valid = 1'b0;
    chk("ls_txn_grant", 32'(got), 32'd1);
    got = 1'b0; rd = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (ls_resp_valid) begin got = 1'b1; rd = ls_resp_data; break; end
    end
    chk("ls_txn_resp", 32'(got), 32'd1);
  endtask

  task automatic run_tie(input logic [31:0] ia, input logic [31:0] la);
    bit dl, di;
    @(posedge clock); #1;
    if_req_addr = ia; if_req_valid = 1'b1;
    ls_req_addr = la; ls_req_wenable = 1'b0; ls_req_wwidth = WRITE_WORD; ls_req_valid = 1'b1;
    for (int c = 0; c < 40 && (ls_req_valid || if_req_valid); c++) begin
      @(negedge clock);
      dl = ls_req_valid && ls_req_ready;
      di = if_req_valid && if_req_ready;
      @(posedge clock); #1;
      if (dl) ls_req_valid = 1'b0;
      if (di) if_req_valid = 1'b0;
    end
    chk("tie_drain", {30'd0, ls_req_valid, if_req_valid}, 32'd0);
    ls_req_valid = 1'b0; if_req_valid = 1'b0;
    repeat (LAT + 2) @(posedge clock);
  endtask

  initial begin
    logic [31:0] rd;
    bit exp_g [9];
    if_req_valid = 0; if_req_addr = '0;
    ls_req_valid = 0; ls_req_addr = '0; ls_req_wenable = 0; ls_req_wwidth = WRITE_BYTE; ls_req_wdata = '0;
    reset = 1'b1;
    repeat (3) @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("reset_addr", mem_ctrl.addr, 32'h0);
    chk("reset_wenable", 32'(mem_ctrl.wenable), 32'd0);
    chk("reset_resp", {30'd0, ls_resp_valid, if_resp_valid}, 32'd0);

    // IF read of word 1
    @(posedge clock); #1;
    if_req_addr = 32'h4; if_req_valid = 1'b1;
    @(negedge clock);
    chk("t1_ready_T", 32'(if_req_ready), 32'd1);
    @(posedge clock); #1;
    if_req_valid = 1'b0;
    @(negedge clock);
    chk("t1_addr_T1", mem_ctrl.addr, 32'h4);
    chk("t1_resp_T1", 32'(if_resp_valid), 32'd0);
    @(negedge clock);
    chk("t1_resp_T2", 32'(if_resp_valid), 32'd1);
    chk("t1_data_T2", if_resp_data, 32'h342D261F);
    chk("t1_addr_T2", mem_ctrl.addr, 32'h4);
    @(negedge clock);
    chk("t1_resp_T3", 32'(if_resp_valid), 32'd0);

    // Word store then load back
    @(posedge clock); #1;
    ls_req_addr = 32'h800; ls_req_wenable = 1'b1; ls_req_wwidth = WRITE_WORD;
    ls_req_wdata = 32'hDEADBEEF; ls_req_valid = 1'b1;
    @(negedge clock);
    chk("t2_ready_T", 32'(ls_req_ready), 32'd1);
    @(posedge clock); #1;
    ls_req_valid = 1'b0;
    @(negedge clock);
    chk("t2_wen_T1", 32'(mem_ctrl.wenable), 32'd1);
    @(negedge clock);
    chk("t2_wen_T2", 32'(mem_ctrl.wenable), 32'd0);
    chk("t2_resp_T2", 32'(ls_resp_valid), 32'd1);
    chk("t2_store_data", ls_resp_data, 32'h0);
    ls_txn(32'h800, 1'b0, WRITE_WORD, 32'h0, rd);
    chk("t2_load_data", rd, 32'hDEADBEEF);

    // Byte store into periph region
    @(posedge clock); #1;
    ls_req_addr = 32'h1800; ls_req_wenable = 1'b1; ls_req_wwidth = WRITE_BYTE;
    ls_req_wdata = 32'h0000005A; ls_req_valid = 1'b1;
    @(negedge clock);
    chk("t5_ready_T", 32'(ls_req_ready), 32'd1);
    @(posedge clock); #1;
    ls_req_valid = 1'b0;
    @(negedge clock);
    chk("t5_resp_T1", 32'(ls_resp_valid), 32'd0);
    @(negedge clock);
    chk("t5_resp_T2", 32'(ls_resp_valid), 32'd1);
    chk("t5_periph0", 32'(dev_mem[13'h1800]), 32'h5A);
    chk("t5_periph1", 32'(dev_mem[13'h1801]), 32'h0A);
    chk("t5_periph2", 32'(dev_mem[13'h1802]), 32'h11);
    chk("t5_periph3", 32'(dev_mem[13'h1803]), 32'h18);
    ls_txn(32'h1800, 1'b0, WRITE_WORD, 32'h0, rd);
    chk("t5_load_data", rd, 32'h18110A5A);

    // Arbitration: single LS grant, then simultaneous IF+LS, three rounds
    grants.delete();
    for (int r = 0; r < 3; r++) begin
      ls_txn(32'h100, 1'b0, WRITE_WORD, 32'h0, rd);
      run_tie(32'h8, 32'h10);
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_g = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
`else
    exp_g = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
`endif
    chk("grant_count", 32'(grants.size()), 32'd9);
    for (int g = 0; g < 9 && g < grants.size(); g++)
      chk($sformatf("grant_%0d_is_ls", g), 32'(grants[g]), 32'(exp_g[g]));

    // Reset during the store strobe cycle
    @(posedge clock); #1;
    ls_req_addr = 32'h900; ls_req_wenable = 1'b1; ls_req_wwidth = WRITE_WORD;
    ls_req_wdata = 32'h12345678; ls_req_valid = 1'b1;
    @(negedge clock);
    chk("t6_ready_T", 32'(ls_req_ready), 32'd1);
    @(posedge clock); #1;
    ls_req_valid = 1'b0;
    chk("t6_wen_before_rst", 32'(mem_ctrl.wenable), 32'd1);
    #1 reset = 1'b1;
    #1 chk("t6_wen_async_drop", 32'(mem_ctrl.wenable), 32'd0);
    repeat (2) @(posedge clock); #1;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      chk("t6_no_resp", {30'd0, ls_resp_valid, if_resp_valid}, 32'd0);
    end
    chk("t6_mem_untouched", 32'(dev_mem[13'h900]), 32'h03);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
